// File: rtl/reboot_pkg.sv
// Shared types and constants for the multiboot reboot scheduler.
package reboot_pkg;

    typedef enum logic [2:0] {StIdle, StQual, StCalc, StIssue, StHold} state_e;

    typedef enum logic [1:0] {SrcHard, SrcWdt, SrcCore} src_e;

    localparam logic [7:0]  ARM_KEY             = 8'hA5;
    localparam int unsigned ARM_WINDOW          = 256;
    localparam logic [11:0] DEFAULT_BASE_PAGE   = 12'h0B0;
    localparam logic [11:0] DEFAULT_CORE_STRIDE = 12'h0C4;

endpackage

// File: rtl/reboot_addr_calc.sv
// Core id range check and flash page computation (purely combinational).
module reboot_addr_calc import reboot_pkg::*; #(
    parameter int unsigned NUM_CORES   = 20,
    parameter logic [11:0] BASE_PAGE   = DEFAULT_BASE_PAGE,
    parameter logic [11:0] CORE_STRIDE = DEFAULT_CORE_STRIDE
) (
    input  logic [4:0]  core_id_i,
    output logic        valid_o,
    output logic [11:0] page_o
);

    localparam logic [5:0] MaxId = 6'(NUM_CORES);

    logic [11:0] idx;

    always_comb begin
        idx     = 12'(core_id_i) - 12'd1;
        valid_o = (core_id_i != 5'd0) && ({1'b0, core_id_i} <= MaxId);
        // Page arithmetic wraps modulo 2^12 by construction.
        page_o  = BASE_PAGE + CORE_STRIDE * idx;
    end

endmodule

// File: rtl/reboot_scheduler.sv
// Arbitrates hard/watchdog/software reboot requests into a one-cycle ICAP multiboot strobe.
// Optional arm-key gating of software requests: define REBOOT_ARM_KEY_EN.
module reboot_scheduler import reboot_pkg::*; #(
    parameter int unsigned NUM_CORES       = 20,
    parameter logic [11:0] BASE_PAGE       = DEFAULT_BASE_PAGE,
    parameter logic [11:0] CORE_STRIDE     = DEFAULT_CORE_STRIDE,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GUARD_CYCLES    = 32
) (
    input  logic        clk_icap,
    input  logic        reset_i,
    input  logic        hard_req,
    input  logic        wdt_req,
    input  logic        core_req,
    input  logic [4:0]  core_id,
    input  logic        arm_we,
    input  logic [7:0]  arm_key,
    output logic        mbt_reboot,
    output logic [23:0] spi_addr,
    output logic        busy,
    output logic        err_invalid
);

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] core_page_q, core_page_d;
    logic [23:0] spi_addr_q, spi_addr_d;
    logic        err_q, err_d;
    logic        hard_pend_q, hard_pend_d;
    logic        hard_s1_q, hard_s2_q, hard_prev_q, wdt_prev_q, core_prev_q;

    logic        hard_edge, wdt_edge, core_edge;
    logic        id_valid, core_ok, arm_consume;
    logic [11:0] calc_page;

    assign hard_edge = hard_s2_q & ~hard_prev_q;
    assign wdt_edge  = wdt_req & ~wdt_prev_q;
    assign core_edge = core_req & ~core_prev_q;

    reboot_addr_calc #(
        .NUM_CORES   (NUM_CORES),
        .BASE_PAGE   (BASE_PAGE),
        .CORE_STRIDE (CORE_STRIDE)
    ) u_addr_calc (
        .core_id_i (core_id),
        .valid_o   (id_valid),
        .page_o    (calc_page)
    );

`ifdef REBOOT_ARM_KEY_EN
    logic       armed_q, armed_d;
    logic [7:0] win_q, win_d;

    always_comb begin
        armed_d = armed_q;
        win_d   = win_q;
        if (armed_q) begin
            if (win_q == 8'(ARM_WINDOW - 1)) armed_d = 1'b0;
            else                             win_d   = win_q + 8'd1;
        end
        if (arm_consume) armed_d = 1'b0;
        if (arm_we) begin
            armed_d = (arm_key == ARM_KEY);
            win_d   = 8'd0;
        end
    end

    always_ff @(posedge clk_icap or posedge reset_i) begin
        if (reset_i) begin
            armed_q <= 1'b0;
            win_q   <= 8'd0;
        end else begin
            armed_q <= armed_d;
            win_q   <= win_d;
        end
    end

    assign core_ok = id_valid & armed_q;
`else
    logic unused_arm;
    assign unused_arm = ^{arm_we, arm_key, arm_consume};
    assign core_ok    = id_valid;
`endif

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        core_page_d = core_page_q;
        spi_addr_d  = spi_addr_q;
        err_d       = err_q;
        hard_pend_d = hard_pend_q;
        arm_consume = 1'b0;

        if (hard_edge && (state_q inside {StCalc, StIssue, StHold})) hard_pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (hard_edge || hard_pend_q) begin
                    state_d     = StQual;
                    src_d       = SrcHard;
                    hard_pend_d = 1'b0;
                end else if (wdt_edge) begin
                    state_d = StCalc;
                    src_d   = SrcWdt;
                    err_d   = 1'b0;
                end else if (core_edge) begin
                    if (core_ok) begin
                        state_d     = StCalc;
                        src_d       = SrcCore;
                        core_page_d = calc_page;
                        err_d       = 1'b0;
                        arm_consume = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StQual: begin
                if (!hard_s2_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCalc: begin
                spi_addr_d = {(src_q == SrcCore) ? core_page_q : BASE_PAGE, 12'h000};
                state_d    = StIssue;
            end
            StIssue: begin
                state_d = StHold;
                cnt_d   = '0;
            end
            StHold: begin
                if (cnt_q == 16'(GUARD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (hard_pend_q || hard_edge) begin
                        state_d     = StQual;
                        src_d       = SrcHard;
                        hard_pend_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_icap or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            src_q       <= SrcHard;
            cnt_q       <= '0;
            core_page_q <= '0;
            spi_addr_q  <= {BASE_PAGE, 12'h000};
            err_q       <= 1'b0;
            hard_pend_q <= 1'b0;
            hard_s1_q   <= 1'b0;
            hard_s2_q   <= 1'b0;
            hard_prev_q <= 1'b0;
            wdt_prev_q  <= 1'b0;
            core_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            core_page_q <= core_page_d;
            spi_addr_q  <= spi_addr_d;
            err_q       <= err_d;
            hard_pend_q <= hard_pend_d;
            hard_s1_q   <= hard_req;
            hard_s2_q   <= hard_s1_q;
            hard_prev_q <= hard_s2_q;
            wdt_prev_q  <= wdt_req;
            core_prev_q <= core_req;
        end
    end

    assign mbt_reboot  = (state_q == StIssue);
    assign busy        = (state_q != StIdle);
    assign spi_addr    = spi_addr_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_reboot_scheduler.sv
// Scoreboard bench for reboot_scheduler: stimulus pushes expected strobes, a monitor checks them.
module tb_reboot_scheduler;

    localparam int GUARD    = 32;
    localparam int DEBOUNCE = 16;

    typedef struct {
        logic [23:0] addr;
        int          cyc;
    } exp_t;

    logic        clk_icap = 1'b0;
    logic        reset_i  = 1'b1;
    logic        hard_req = 1'b0;
    logic        wdt_req  = 1'b0;
    logic        core_req = 1'b0;
    logic [4:0]  core_id  = 5'd0;
    logic        arm_we   = 1'b0;
    logic [7:0]  arm_key  = 8'd0;
    logic        mbt_reboot;
    logic [23:0] spi_addr;
    logic        busy;
    logic        err_invalid;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    reboot_scheduler u_dut (
        .clk_icap    (clk_icap),
        .reset_i     (reset_i),
        .hard_req    (hard_req),
        .wdt_req     (wdt_req),
        .core_req    (core_req),
        .core_id     (core_id),
        .arm_we      (arm_we),
        .arm_key     (arm_key),
        .mbt_reboot  (mbt_reboot),
        .spi_addr    (spi_addr),
        .busy        (busy),
        .err_invalid (err_invalid)
    );

    always #5 clk_icap = ~clk_icap;
    always @(posedge clk_icap) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk_icap) begin
        if (!reset_i && mbt_reboot) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got spi_addr %h, expected no strobe", spi_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_addr", 32'(spi_addr), 32'(e.addr));
                if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_icap);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            tick(1);
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic core_request(input logic [4:0] id, input logic [23:0] addr);
        exp_t e;
        e.addr = addr;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        core_id  = id;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        core_id  = 5'h1F;
        wait_idle();
        check("spi_addr_kept", 32'(spi_addr), 32'(addr));
        check("err_cleared", 32'(err_invalid), 32'd0);
    endtask

    task automatic core_reject(input logic [4:0] id);
        core_id  = id;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        check("reject_err", 32'(err_invalid), 32'd1);
        check("reject_busy", 32'(busy), 32'd0);
        tick(4);
    endtask

    initial begin
        exp_t e;
        int   d;
        int   k;
        int   nb;

        tick(3);
        check("rst_mbt", 32'(mbt_reboot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_invalid), 32'd0);
        check("rst_addr", 32'(spi_addr), 32'h0B0000);
        reset_i = 1'b0;
        tick(2);

        core_request(5'd1, 24'h0B0000);
        core_request(5'd2, 24'h174000);
        core_request(5'd20, 24'hF3C000);

        core_reject(5'd0);
        core_request(5'd3, 24'h238000);
        core_reject(5'd21);
        core_request(5'd3, 24'h238000);

        // Short press: rejected by debounce.
        hard_req = 1'b1;
        tick(10);
        hard_req = 1'b0;
        tick(30);
        check("short_press_idle", 32'(busy), 32'd0);

        // Long press: one strobe at the base page, then GUARD busy cycles.
        e.addr = 24'h0B0000;
        e.cyc  = -1;
        exp_q.push_back(e);
        hard_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk_icap);
            k++;
        end while (!mbt_reboot && k < 100);
        check("hard_strobe_seen", 32'(mbt_reboot), 32'd1);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_icap);
            if (busy) nb++;
            else break;
        end
        check("hold_busy_cycles", nb, GUARD);
        hard_req = 1'b0;
        tick(5);

        // wdt and core together: wdt wins; hard during HOLD is served afterwards.
        d = cyc;
        e.addr = 24'h0B0000;
        e.cyc  = d + 2;
        exp_q.push_back(e);
        wdt_req  = 1'b1;
        core_req = 1'b1;
        core_id  = 5'd5;
        tick(1);
        wdt_req  = 1'b0;
        core_req = 1'b0;
        tick(4);
        check("hold_busy", 32'(busy), 32'd1);
        e.addr = 24'h0B0000;
        e.cyc  = d + 2 + GUARD + DEBOUNCE + 2;
        exp_q.push_back(e);
        hard_req = 1'b1;
        core_id  = 5'd4;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        tick(60);
        hard_req = 1'b0;
        wait_idle();
        check("pending_served", exp_q.size(), 0);

`ifdef REBOOT_ARM_KEY_EN
        core_reject(5'd1);
        arm_key = 8'hA5;
        arm_we  = 1'b1;
        tick(1);
        arm_we = 1'b0;
        tick(99);
        core_request(5'd1, 24'h0B0000);
        arm_we = 1'b1;
        tick(1);
        arm_we = 1'b0;
        tick(299);
        core_reject(5'd1);
`else
        arm_key = 8'h00;
        arm_we  = 1'b1;
        tick(1);
        arm_we = 1'b0;
        core_request(5'd4, 24'h2FC000);
`endif

        // Reset during QUAL.
        core_request(5'd2, 24'h174000);
        core_reject(5'd0);
        hard_req = 1'b1;
        tick(8);
        check("qual_busy", 32'(busy), 32'd1);
        reset_i = 1'b1;
        #1;
        check("rstq_busy", 32'(busy), 32'd0);
        check("rstq_addr", 32'(spi_addr), 32'h0B0000);
        check("rstq_err", 32'(err_invalid), 32'd0);
        check("rstq_mbt", 32'(mbt_reboot), 32'd0);
        hard_req = 1'b0;
        tick(3);
        reset_i = 1'b0;
        tick(60);
        check("rstq_quiet", 32'(busy), 32'd0);

        // Reset during HOLD.
        d = cyc;
        e.addr = 24'h174000;
        e.cyc  = d + 2;
        exp_q.push_back(e);
        core_id  = 5'd2;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        tick(5);
        check("hold_before_rst", 32'(busy), 32'd1);
        reset_i = 1'b1;
        #1;
        check("rsth_busy", 32'(busy), 32'd0);
        check("rsth_addr", 32'(spi_addr), 32'h0B0000);
        tick(3);
        reset_i = 1'b0;
        tick(50);
        check("rsth_quiet", 32'(busy), 32'd0);

        check("leftover_expected", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
